// File: rtl/ld19_uart_tx.sv
// 8N1 UART transmitter with a byte FIFO and valid/ready push port, for the LD19 lidar RX line.
// Define LD19_TX_CRC8_EN to append a CRC8 (poly 0x4D) frame after each byte pushed with s_last=1.
module ld19_uart_tx #(
    parameter int CLKS_PER_BIT = 52,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] LAST_TICK  = TW'(CLKS_PER_BIT - 1);
`ifdef LD19_TX_CRC8_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [EW-1:0]   head;
    logic [EW-1:0]   entry_in;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop, load, tick_end;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

`ifdef LD19_TX_CRC8_EN
    logic [7:0]      crc;
    logic            crc_pend;
    logic            load_crc;

    // MSB-first CRC8, poly 0x4D, one bit per unrolled iteration.
    function automatic logic [7:0] crc8_next(input logic [7:0] cur, input logic [7:0] data);
        logic [7:0] c;
        c = cur ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h4D) : {c[6:0], 1'b0};
        return c;
    endfunction

    assign entry_in = {s_last, s_data};
`else
    logic unused_last;
    assign unused_last = s_last;
    assign entry_in    = s_data;
`endif

    assign head     = mem[rd_ptr];
    assign s_ready  = (fifo_count < FULL_COUNT) && !reset;
    assign push     = s_valid && s_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign tick_end = (timer == LAST_TICK);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry_in;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
`ifdef LD19_TX_CRC8_EN
        load_crc   = 1'b0;
`endif
        case (state)
            IDLE:
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = START;
                end
            START:
                if (tick_end) state_next = DATA;
            DATA:
                if (tick_end && bit_idx == 3'd7) state_next = STOP;
            STOP:
                if (tick_end) begin
`ifdef LD19_TX_CRC8_EN
                    if (crc_pend) begin
                        load_crc   = 1'b1;
                        state_next = START;
                    end else
`endif
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        load       = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            default: state_next = IDLE;
        endcase
    end

    // tx follows the state one cycle later, so the line is always driven from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
`ifdef LD19_TX_CRC8_EN
            crc      <= 8'h00;
            crc_pend <= 1'b0;
`endif
        end else begin
            state <= state_next;
            timer <= (state == IDLE || tick_end) ? '0 : timer + TW'(1);
            if (state == DATA && tick_end) bit_idx <= bit_idx + 3'd1;
            if (load) shift <= head[7:0];
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[bit_idx];
                default: tx <= 1'b1;
            endcase
`ifdef LD19_TX_CRC8_EN
            if (load) begin
                crc      <= crc8_next(crc, head[7:0]);
                crc_pend <= head[8];
            end
            if (load_crc) begin
                shift    <= crc;
                crc      <= 8'h00;
                crc_pend <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ld19_uart_tx.sv
// Self-checking bench for ld19_uart_tx: table-driven single frames, a line decoder with a
// scoreboard queue, and hand sequences for back-to-back, FIFO-full, mid-frame reset and CRC.
module tb_ld19_uart_tx;

    localparam int BIT = 52;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         starts[$];
    int         frames_seen = 0;
    logic [9:0] last_bits;
    bit         frame_abort = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;
    vec_t vecs[4];

    ld19_uart_tx dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

`ifdef LD19_TX_CRC8_EN
    logic [7:0] model_crc = 8'h00;

    function automatic logic [7:0] crc_model(input logic [7:0] cur, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = cur;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h4D : 8'h00);
        end
        return c;
    endfunction
`endif

    task automatic sb_push(input logic [7:0] d, input logic l);
        exp_q.push_back(d);
`ifdef LD19_TX_CRC8_EN
        model_crc = crc_model(model_crc, d);
        if (l) begin
            exp_q.push_back(model_crc);
            model_crc = 8'h00;
        end
`else
        if (l) exp_q.push_back(d) ; // never reached usefully: last is ignored without CRC
        if (l) void'(exp_q.pop_back());
`endif
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Caller must be just after a posedge; on return it is #1 after the push edge.
    task automatic push_one(input logic [7:0] d, input logic l, output int edge_cyc, output logic accepted);
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        @(negedge clk);
        accepted = s_ready;
        @(posedge clk);
        #1;
        edge_cyc = cyc;
        s_valid  = 1'b0;
        if (accepted) sb_push(d, l);
    endtask

    task automatic wait_idle(input string name, input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                at_cyc = cyc;
                break;
            end
        end
        check({name, "_idle_in_time"}, at_cyc >= 0, 1);
    endtask

    // Line decoder: samples each bit at its midpoint and checks against the scoreboard.
    initial begin : monitor
        int         st;
        logic [9:0] bits;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                st = cyc;
                for (int b = 0; b < 10; b++) begin
                    repeat (b == 0 ? BIT / 2 : BIT) @(negedge clk);
                    bits[b] = tx;
                end
                if (frame_abort) begin
                    frame_abort = 1'b0;
                end else begin
                    frames_seen++;
                    starts.push_back(st);
                    last_bits = bits;
                    check("stop_bit", bits[9], 1'b1);
                    check("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("frame_byte", bits[8:1], exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int   pc, pc0, drop, nf, acc, low_cnt;
        logic ok;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h01, 10'b1000000010};
        vecs[2] = '{8'h80, 10'b1100000000};
        vecs[3] = '{8'h3C, 10'b1001111000};

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 5'd0);
        check("rst_ready_low", s_ready, 1'b0);
        sync();
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", s_ready, 1'b1);

        // Single frames: line pattern, push-to-start latency and busy length.
        for (int v = 0; v < 4; v++) begin
            nf = frames_seen;
            sync();
            push_one(vecs[v].data, 1'b0, pc, ok);
            check("vec_accepted", ok, 1'b1);
            wait_idle("vec", FRAME + 100, drop);
            check("vec_frames", frames_seen - nf, 1);
            check("vec_line", last_bits, vecs[v].line);
            check("vec_latency", starts[$] - pc, 2);
            // one pop cycle plus the 520-cycle frame
            check("vec_busy_len", drop - pc, FRAME + 1);
        end

        // Three back-to-back frames must be contiguous.
        nf = frames_seen;
        sync();
        push_one(8'h00, 1'b0, pc0, ok);
        push_one(8'hFF, 1'b0, pc, ok);
        push_one(8'h55, 1'b0, pc, ok);
        wait_idle("b2b", 3 * FRAME + 100, drop);
        check("b2b_frames", frames_seen - nf, 3);
        check("b2b_gap1", starts[$ - 1] - starts[$ - 2], FRAME);
        check("b2b_gap2", starts[$] - starts[$ - 1], FRAME);
        check("b2b_total", drop - pc0, 3 * FRAME + 1);

        // Hold valid for 20 cycles while the first frame stalls the FIFO.
        nf  = frames_seen;
        acc = 0;
        sync();
        for (int i = 0; i < 20; i++) begin
            push_one(8'h10 + 8'(acc), 1'b0, pc, ok);
            if (i == 0) pc0 = pc;
            if (ok) acc++;
        end
        @(negedge clk);
        check("full_accepted", acc, 17);
        check("full_count", fifo_count, 5'd16);
        check("full_ready_low", s_ready, 1'b0);
        wait_idle("full", 17 * FRAME + 200, drop);
        check("full_frames", frames_seen - nf, 17);
        check("full_drained", exp_q.size(), 0);
        check("full_total", drop - pc0, 17 * FRAME + 1);

        // Reset in the middle of DATA bit 4 with five bytes queued.
        nf = frames_seen;
        sync();
        push_one(8'h61, 1'b0, pc0, ok);
        for (int i = 0; i < 5; i++) push_one(8'h62 + 8'(i), 1'b0, pc, ok);
        while (cyc < pc0 + 1 + 5 * BIT + BIT / 2) sync();
        check("mid_bit4_tx", tx, 1'b0);
        check("mid_count", fifo_count, 5'd5);
        frame_abort = 1'b1;
        exp_q.delete();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_count", fifo_count, 5'd0);
        check("rst_mid_busy", busy, 1'b0);
        low_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) low_cnt++;
        end
        check("rst_mid_quiet", low_cnt, 0);
        check("rst_mid_no_frames", frames_seen - nf, 0);

`ifdef LD19_TX_CRC8_EN
        // One-byte packet: data frame then its CRC frame.
        nf = frames_seen;
        sync();
        push_one(8'h54, 1'b1, pc0, ok);
        wait_idle("crc1", 2 * FRAME + 100, drop);
        check("crc1_frames", frames_seen - nf, 2);
        check("crc1_value", last_bits[8:1], 8'hEE);
        check("crc1_gap", starts[$] - starts[$ - 1], FRAME);
        check("crc1_busy_len", drop - pc0, 2 * FRAME + 1);

        // Two packets: CRC must restart from zero for the second one.
        nf = frames_seen;
        sync();
        push_one(8'h54, 1'b1, pc0, ok);
        push_one(8'h54, 1'b1, pc, ok);
        wait_idle("crc2", 4 * FRAME + 100, drop);
        check("crc2_frames", frames_seen - nf, 4);
        check("crc2_value", last_bits[8:1], 8'hEE);
        check("crc2_total", drop - pc0, 4 * FRAME + 1);
`else
        // Without CRC support, s_last must not add a frame.
        nf = frames_seen;
        sync();
        push_one(8'h54, 1'b1, pc0, ok);
        wait_idle("nocrc", 2 * FRAME + 100, drop);
        check("nocrc_frames", frames_seen - nf, 1);
        check("nocrc_busy_len", drop - pc0, FRAME + 1);
`endif

        repeat (FRAME) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ld19_uart_tx.md
Name: ld19_uart_tx

Overview:
- 8N1 UART transmitter with an input byte FIFO and a valid/ready push interface.
- Runs at 230400 baud from the 12 MHz system clock.
- Drives the LD19 lidar UART RX line and is the loopback source for bench testing of the LD19 receive path.
- Optional per-packet CRC8 append matching the LD19 frame check (poly 0x4D).

Parameters:
- CLKS_PER_BIT, 52, clk cycles per UART bit (12 MHz / 230400 ~= 52.08).
- FIFO_DEPTH, 16, byte FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- s_data  in  8  byte to transmit
- s_valid  in  1  s_data valid
- s_last  in  1  marks last byte of a packet (used only with CRC feature)
- s_ready  out  1  FIFO can accept; push occurs when s_valid && s_ready at posedge
- tx  out  1  serial line, idle high, registered
- busy  out  1  high while a frame is on the line or FIFO is non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- Reset values: tx=1, busy=0, fifo_count=0, FSM=IDLE, CRC=0x00. s_ready=0 while reset is high and =1 on the first cycle after.
- s_ready = (fifo_count < FIFO_DEPTH) && !reset. A push when full is impossible by construction.
- A simultaneous push and pop in the same cycle leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head byte into the shift register, load the bit timer, go to START. tx=0 is registered on the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles. A 3-bit index counts 0..7, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO is non-empty (or a CRC byte is pending), go directly to START with no idle gap; else go to IDLE.
- Latency: a byte pushed into an empty FIFO with the FSM in IDLE at edge N is popped at edge N+1; tx falls at edge N+2.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- The bit timer counts 0..CLKS_PER_BIT-1 and has width $clog2(CLKS_PER_BIT).
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count is a full-width counter, not a pointer difference.
- busy = (FSM != IDLE) || (fifo_count != 0).
- Reset mid-frame: the line returns to tx=1 on the reset edge. FIFO contents are discarded and no partial frame resumes.

Optional Feature:
- Macro: LD19_TX_CRC8_EN.
- Enabled:
  - FIFO entries are 9 bits {s_last, s_data}.
  - A running CRC8 is updated with each byte as it is popped. Parameters: poly 0x4D, init 0x00, MSB-first, no reflection, no final XOR. The update is a bit-serial loop unrolled combinationally.
  - After the STOP of a byte popped with last=1, one extra frame carrying the CRC value is sent back-to-back. The CRC then resets to 0x00.
  - busy stays high until the CRC frame's STOP completes.
  - Pushes continue to be accepted during the CRC frame.
- Disabled:
  - s_last is ignored, FIFO is 8 bits wide, and no CRC logic is present.

Test Plan:
- Reset release, push 0xA5 once -> tx falls 2 cycles after the push edge; line bits are 0,1,0,1,0,0,1,0,1,1, each held 52 cycles; busy drops after 520 cycles.
- Push 0x00, 0xFF, 0x55 back-to-back -> 3 contiguous frames totalling 1560 cycles, no idle high between stop and next start; decoded bytes in order.
- Hold s_valid for 20 pushes with the FSM stalled by the first frame -> s_ready low once fifo_count=16; exactly 17 bytes accepted (1 in flight + 16 queued); all 17 transmitted in order, wrap-around correct.
- Assert reset for 1 cycle in the middle of DATA bit 4 of a frame with 5 bytes queued -> tx=1 the next cycle, fifo_count=0, busy=0; no further frames.
- LD19_TX_CRC8_EN defined, push 0x54 with s_last=1 -> two frames: 0x54 then 0xEE.
- LD19_TX_CRC8_EN defined, push 0x54 (last=1) then 0x54 (last=1) -> frames 0x54, 0xEE, 0x54, 0xEE, showing the CRC resets between packets.
